// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit/receive paths.
package i2s_pkg;

  localparam int slots_per_channel_lp = 32;
  localparam int mclk_per_lrck_lp     = 256;
  localparam int slot_w_lp            = $clog2(slots_per_channel_lp);

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_clkgen.sv
// Free-running I2S clock generator: mclk/sclk/lrck taken straight from counter
// bits, plus the slot index and the sclk-fall / frame-end strobes.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int mclk_div_log2_p = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  output logic                 mclk_o,
  output logic                 sclk_o,
  output logic                 lrck_o,
  output logic [slot_w_lp-1:0] slot_o,
  output logic                 sclk_fall_o,
  output logic                 frame_end_o
);

  localparam int cnt_w_lp = mclk_div_log2_p + 8;

  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + cnt_w_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign mclk_o      = cnt_q[mclk_div_log2_p-1];
  assign sclk_o      = cnt_q[mclk_div_log2_p+1];
  assign lrck_o      = cnt_q[cnt_w_lp-1];
  assign slot_o      = cnt_q[cnt_w_lp-2 -: slot_w_lp];
  // Strobes mark the last cycle before the low bits / whole counter wrap.
  assign sclk_fall_o = &cnt_q[mclk_div_log2_p+1:0];
  assign frame_end_o = &cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S line-out transmitter with a one-pair holding buffer.
// Optional I2S_TX_HOLD_LAST_EN: on underrun, repeat the last transmitted pair.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int width_p         = 24,
  parameter int mclk_div_log2_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_left_i,
  input  logic [width_p-1:0] data_right_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               mclk_o,
  output logic               lrck_o,
  output logic               sclk_o,
  output logic               sdout_o,
  output logic               underrun_o
);

  logic                 sclk_fall, frame_end;
  logic [slot_w_lp-1:0] slot, slot_next;
  logic                 accept;

  logic                   full_q, full_d;
  logic [2*width_p-1:0]   buf_q, buf_d;
  logic [2*width_p-1:0]   sr_q, sr_d;
  logic                   sdout_q, sdout_d;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [2*width_p-1:0]   last_q, last_d;
`endif

  i2s_clkgen #(
    .mclk_div_log2_p(mclk_div_log2_p)
  ) u_clkgen (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .mclk_o     (mclk_o),
    .sclk_o     (sclk_o),
    .lrck_o     (lrck_o),
    .slot_o     (slot),
    .sclk_fall_o(sclk_fall),
    .frame_end_o(frame_end)
  );

  assign accept    = valid_i & ~full_q;
  assign slot_next = slot + slot_w_lp'(1);

  always_comb begin
    full_d  = full_q;
    buf_d   = buf_q;
    sr_d    = sr_q;
    sdout_d = sdout_q;
`ifdef I2S_TX_HOLD_LAST_EN
    last_d  = last_q;
`endif
    if (accept) begin
      full_d = 1'b1;
      buf_d  = {data_left_i, data_right_i};
    end
    // A pair accepted on the frame-end cycle waits for the next frame.
    if (frame_end) begin
      if (full_q) begin
        sr_d   = buf_q;
        full_d = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d = buf_q;
`endif
      end else begin
`ifdef I2S_TX_HOLD_LAST_EN
        sr_d = last_q;
`else
        sr_d = '0;
`endif
      end
    end
    // Left bits leave first; the right half follows in the second half-frame.
    if (sclk_fall) begin
      if (slot_next != '0 && int'(slot_next) <= width_p) begin
        sdout_d = sr_q[2*width_p-1];
        sr_d    = {sr_q[2*width_p-2:0], 1'b0};
      end else begin
        sdout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q  <= 1'b0;
      buf_q   <= '0;
      sr_q    <= '0;
      sdout_q <= 1'b0;
    end else begin
      full_q  <= full_d;
      buf_q   <= buf_d;
      sr_q    <= sr_d;
      sdout_q <= sdout_d;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) last_q <= '0;
    else            last_q <= last_d;
  end
`endif

  assign ready_o    = ~full_q;
  assign sdout_o    = sdout_q;
  assign underrun_o = frame_end & ~full_q;

endmodule
